// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: grant/state encodings
// and the framebuffer coordinate-to-word mapping.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR,
    GNT_DL
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int FB_COORD_W = 21;

  // One word per pixel; frame select is the top bit of the 21-bit offset.
  function automatic logic [FB_COORD_W-1:0] fb_addr(
    input logic       frame,
    input logic [9:0] row,
    input logic [9:0] col
  );
    return {frame, row, col};
  endfunction

endpackage

// File: rtl/sdram_arb_prio.sv
// Priority select (rd > wr > dl, flipping to wr > dl > rd once rd has starved the
// others STARVE_MAX times) plus the saturating starve counter. Grant is combinational.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic   clk_96,
  input  logic   reset_n,
  input  logic   arb_en,
  input  logic   rd_req,
  input  logic   wr_req,
  input  logic   dl_req,
  output grant_t grant
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (starved) begin
      if (wr_req)      grant = GNT_WR;
      else if (dl_req) grant = GNT_DL;
      else if (rd_req) grant = GNT_RD;
    end else begin
      if (rd_req)      grant = GNT_RD;
      else if (wr_req) grant = GNT_WR;
      else if (dl_req) grant = GNT_DL;
    end
  end

  // Only real grant cycles move the counter; a stalled IDLE leaves it alone.
  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (grant == GNT_WR || grant == GNT_DL) begin
        starve_cnt <= '0;
      end else if (grant == GNT_RD && (wr_req || dl_req) && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM request port between fb reader, fb writer and download writer;
// one access at a time, >=4 cycles + controller latency. Optional stats: ARB_STATS_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] FB_BASE    = 22'h200000,
  parameter logic [ADDR_W-1:0] DL_BASE    = 22'h000000,
  parameter int                STARVE_MAX = 8
) (
  input  logic              clk_96,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic              rd_frame,
  input  logic [9:0]        rd_row,
  input  logic [9:0]        rd_col,
  output logic [15:0]       rd_q,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic              wr_frame,
  input  logic [9:0]        wr_row,
  input  logic [9:0]        wr_col,
  input  logic [15:0]       wr_d,
  output logic              wr_ack,
  input  logic              dl_req,
  input  logic [15:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ack,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_dqm,
  input  logic [15:0]       mem_q,
  input  logic              mem_ack
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_dl,
  output logic [15:0]       stat_starve
`endif
);

  state_t            state;
  state_t            state_nxt;
  grant_t            sel;
  grant_t            gnt;
  logic              arb_en;
  logic              do_grant;
  logic              ack_hit;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [15:0]       nxt_din;
  logic [1:0]        nxt_dqm;

  sdram_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk_96 (clk_96),
    .reset_n(reset_n),
    .arb_en (arb_en),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .dl_req (dl_req),
    .grant  (sel)
  );

  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (do_grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_ack) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // mem_ack is only meaningful in WAIT; requests only in IDLE with the controller up.
  always_comb begin
    arb_en   = (state == ST_IDLE) && mem_ready;
    do_grant = arb_en && (sel != GNT_NONE);
    ack_hit  = (state == ST_WAIT) && mem_ack;
  end

  always_comb begin
    nxt_we   = mem_we;
    nxt_addr = mem_addr;
    nxt_din  = mem_din;
    nxt_dqm  = mem_dqm;
    case (sel)
      GNT_RD: begin
        nxt_we   = 1'b0;
        nxt_addr = FB_BASE + ADDR_W'(fb_addr(rd_frame, rd_row, rd_col));
        nxt_din  = '0;
        nxt_dqm  = 2'b00;
      end
      GNT_WR: begin
        nxt_we   = 1'b1;
        nxt_addr = FB_BASE + ADDR_W'(fb_addr(wr_frame, wr_row, wr_col));
        nxt_din  = wr_d;
        nxt_dqm  = 2'b00;
      end
      GNT_DL: begin
        // Byte writes go to both lanes; the mask picks the lane (odd byte = high).
        nxt_we   = 1'b1;
        nxt_addr = DL_BASE + ADDR_W'(dl_addr[15:1]);
        nxt_din  = {dl_data, dl_data};
        nxt_dqm  = dl_addr[0] ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= GNT_NONE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_dqm  <= 2'b00;
      rd_q     <= '0;
      rd_ack   <= 1'b0;
      wr_ack   <= 1'b0;
      dl_ack   <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      wr_ack <= 1'b0;
      dl_ack <= 1'b0;
      if (do_grant) begin
        gnt      <= sel;
        mem_req  <= 1'b1;
        mem_we   <= nxt_we;
        mem_addr <= nxt_addr;
        mem_din  <= nxt_din;
        mem_dqm  <= nxt_dqm;
      end
      if (ack_hit) begin
        mem_req <= 1'b0;
        if (gnt == GNT_RD) rd_q <= mem_q;
        rd_ack <= (gnt == GNT_RD);
        wr_ack <= (gnt == GNT_WR);
        dl_ack <= (gnt == GNT_DL);
      end
      if (state == ST_DONE) gnt <= GNT_NONE;
    end
  end

`ifdef ARB_STATS_EN
  // rd only loses a grant while requesting when the starve override is active.
  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd     <= '0;
      stat_wr     <= '0;
      stat_dl     <= '0;
      stat_starve <= '0;
    end else begin
      if (ack_hit && gnt == GNT_RD && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      if (ack_hit && gnt == GNT_WR && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      if (ack_hit && gnt == GNT_DL && stat_dl != 16'hFFFF) stat_dl <= stat_dl + 16'd1;
      if (do_grant && rd_req && (sel == GNT_WR || sel == GNT_DL) &&
          stat_starve != 16'hFFFF) begin
        stat_starve <= stat_starve + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: requesters push expected accesses, a controller model acks
// with random latency, and a monitor checks grants, bus contents and acks.
module tb_sdram_port_arbiter;

  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_DL   = 3;

  logic        clk_96 = 1'b0;
  logic        reset_n;
  logic        rd_req, rd_frame;
  logic [9:0]  rd_row, rd_col;
  logic [15:0] rd_q;
  logic        rd_ack;
  logic        wr_req, wr_frame;
  logic [9:0]  wr_row, wr_col;
  logic [15:0] wr_d;
  logic        wr_ack;
  logic        dl_req;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ack;
  logic        mem_ready;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_dqm;
  logic [15:0] mem_q;
  logic        mem_ack;
`ifdef ARB_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_dl, stat_starve;
`endif

  always #5 clk_96 = ~clk_96;

  sdram_port_arbiter dut (
    .clk_96(clk_96), .reset_n(reset_n),
    .rd_req(rd_req), .rd_frame(rd_frame), .rd_row(rd_row), .rd_col(rd_col),
    .rd_q(rd_q), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_frame(wr_frame), .wr_row(wr_row), .wr_col(wr_col),
    .wr_d(wr_d), .wr_ack(wr_ack),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dqm(mem_dqm),
    .mem_q(mem_q), .mem_ack(mem_ack)
`ifdef ARB_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_dl(stat_dl), .stat_starve(stat_starve)
`endif
  );

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [15:0] din;
    logic [1:0]  dqm;
  } acc_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] q;
  } ackexp_t;

  int checks = 0;
  int errors = 0;

  acc_t    exp_rd[$];
  acc_t    exp_wr[$];
  acc_t    exp_dl[$];
  ackexp_t ackq[$];
  int      grant_log[$];
  bit      log_en = 0;
  int      accesses = 0;
  int      ack_cnt[4] = '{0, 0, 0, 0};
  int      cur_kind = K_NONE;
  int      starve_m = 0;

  int          fixed_lat = 0;
  bit          fixed_q_en = 0;
  logic [15:0] fixed_q = 16'h0;

  bit auto_rd = 0, auto_wr = 0, auto_dl = 0, rand_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] fb_word(input int frame, input int row, input int col);
    return 22'(32'h200000 + frame * 32'h100000 + row * 1024 + col);
  endfunction

  task automatic raise_rd(input int frame, input int row, input int col);
    rd_frame = frame[0]; rd_row = 10'(row); rd_col = 10'(col); rd_req = 1'b1;
    exp_rd.push_back('{we: 1'b0, addr: fb_word(frame, row, col), din: 16'h0, dqm: 2'b00});
  endtask

  task automatic raise_wr(input int frame, input int row, input int col, input logic [15:0] d);
    wr_frame = frame[0]; wr_row = 10'(row); wr_col = 10'(col); wr_d = d; wr_req = 1'b1;
    exp_wr.push_back('{we: 1'b1, addr: fb_word(frame, row, col), din: d, dqm: 2'b00});
  endtask

  task automatic raise_dl(input logic [15:0] a, input logic [7:0] d);
    dl_addr = a; dl_data = d; dl_req = 1'b1;
    exp_dl.push_back('{we: 1'b1, addr: 22'(a / 2), din: 16'(d) * 16'd257,
                       dqm: (a % 2 == 1) ? 2'b01 : 2'b10});
  endtask

  // Priority as a plain rule: rd first unless the others lost STARVE_MAX=8 times.
  function automatic int model_pick(input logic [2:0] reqs);
    int win;
    win = K_NONE;
    if (starve_m == 8) begin
      if (reqs[1])      win = K_WR;
      else if (reqs[0]) win = K_DL;
      else if (reqs[2]) win = K_RD;
    end else begin
      if (reqs[2])      win = K_RD;
      else if (reqs[1]) win = K_WR;
      else if (reqs[0]) win = K_DL;
    end
    if (win == K_RD && (reqs[1] || reqs[0]) && starve_m < 8) starve_m++;
    if (win == K_WR || win == K_DL) starve_m = 0;
    return win;
  endfunction

  // SDRAM controller model.
  initial begin : responder
    bit busy;
    int lat;
    busy = 0; lat = 0;
    mem_ack = 1'b0; mem_q = 16'h0;
    forever begin
      @(negedge clk_96);
      if (!reset_n) begin
        mem_ack = 1'b0; busy = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (busy) begin
        if (lat > 1) lat--;
        else begin
          mem_q = fixed_q_en ? fixed_q : 16'($urandom);
          mem_ack = 1'b1;
          busy = 0;
          ackq.push_back('{kind: 2'(cur_kind), q: mem_q});
        end
      end else if (mem_req) begin
        busy = 1;
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;  // stray pulse outside WAIT, must be ignored
      end
    end
  end

  initial begin : monitor
    logic       prev_mem_req;
    logic       prev_ready;
    logic [2:0] prev_reqs;
    acc_t       e;
    ackexp_t    a;
    int         win;
    logic [2:0] exp_hot;
    prev_mem_req = 0; prev_ready = 0; prev_reqs = 0;
    forever begin
      @(negedge clk_96);
      if (!reset_n) begin
        starve_m = 0; cur_kind = K_NONE; ackq.delete(); prev_mem_req = 0;
      end else begin
        if (mem_req && !prev_mem_req) begin
          chk("grant_needs_ready", prev_ready, 1);
          chk("pending_at_grant", |prev_reqs, 1);
          win = model_pick(prev_reqs);
          if (win != K_NONE) begin
            if (win == K_RD) chk("rd_exp_avail", exp_rd.size() > 0, 1);
            if (win == K_WR) chk("wr_exp_avail", exp_wr.size() > 0, 1);
            if (win == K_DL) chk("dl_exp_avail", exp_dl.size() > 0, 1);
            e = '0;
            if (win == K_RD && exp_rd.size() > 0) e = exp_rd[0];
            if (win == K_WR && exp_wr.size() > 0) e = exp_wr[0];
            if (win == K_DL && exp_dl.size() > 0) e = exp_dl[0];
            chk($sformatf("access_k%0d", win),
                {mem_we, mem_addr, e.we ? mem_din : 16'h0, mem_dqm}, e);
          end
          cur_kind = win;
          accesses++;
          if (log_en) grant_log.push_back(win);
        end
        if (rd_ack || wr_ack || dl_ack) begin
          chk("mem_req_low_at_ack", mem_req, 0);
          if (ackq.size() == 0) begin
            chk("unexpected_ack", {rd_ack, wr_ack, dl_ack}, 0);
          end else begin
            a = ackq.pop_front();
            exp_hot = (a.kind == 2'(K_RD)) ? 3'b100 : (a.kind == 2'(K_WR)) ? 3'b010 : 3'b001;
            chk("ack_select", {rd_ack, wr_ack, dl_ack}, exp_hot);
            if (a.kind == 2'(K_RD)) chk("rd_q", rd_q, a.q);
            ack_cnt[int'(a.kind)]++;
            if (a.kind == 2'(K_RD) && exp_rd.size() > 0) void'(exp_rd.pop_front());
            if (a.kind == 2'(K_WR) && exp_wr.size() > 0) void'(exp_wr.pop_front());
            if (a.kind == 2'(K_DL) && exp_dl.size() > 0) void'(exp_dl.pop_front());
          end
        end
        prev_mem_req = mem_req;
      end
      prev_reqs  = {rd_req, wr_req, dl_req};
      prev_ready = mem_ready;
    end
  end

  // Requester agent: drop on ack, optionally re-raise, then random traffic.
  task automatic step();
    @(posedge clk_96);
    #2;
    if (rd_ack) rd_req = 1'b0;
    if (wr_ack) wr_req = 1'b0;
    if (dl_ack) dl_req = 1'b0;
    if (!rd_req && (auto_rd || (rand_mode && $urandom_range(0, 3) == 0)))
      raise_rd($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
    if (!wr_req && (auto_wr || (rand_mode && $urandom_range(0, 3) == 0)))
      raise_wr($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
               16'($urandom));
    if (!dl_req && (auto_dl || (rand_mode && $urandom_range(0, 3) == 0)))
      raise_dl(16'($urandom), 8'($urandom));
    if (rand_mode) begin
      if (mem_ready && $urandom_range(0, 31) == 0) mem_ready = 1'b0;
      else if (!mem_ready && $urandom_range(0, 2) == 0) mem_ready = 1'b1;
    end
  endtask

  task automatic quiet();
    int n;
    n = 0;
    while ((rd_req || wr_req || dl_req || mem_req || rd_ack || wr_ack || dl_ack) && n < 3000) begin
      step();
      n++;
    end
    chk("settle_within_budget", n < 3000, 1);
  endtask

  initial begin : stimulus
    int base;
    int base_wr;
    int n;
    reset_n = 1'b1;
    mem_ready = 1'b0;
    rd_req = 0; rd_frame = 0; rd_row = 0; rd_col = 0;
    wr_req = 0; wr_frame = 0; wr_row = 0; wr_col = 0; wr_d = 0;
    dl_req = 0; dl_addr = 0; dl_data = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk_96);
    #2;
    chk("reset_mem_bus", {mem_req, mem_we, mem_addr, mem_din, mem_dqm}, 0);
    chk("reset_rd_side", {rd_q, rd_ack, wr_ack, dl_ack}, 0);
    reset_n = 1'b1;

    // Controller not ready: the held read must wait, then go out once.
    fixed_lat = 6; fixed_q_en = 1; fixed_q = 16'hBEEF;
    raise_rd(0, 5, 7);
    base = accesses;
    repeat (20) begin
      step();
      chk("no_req_while_not_ready", mem_req, 0);
    end
    mem_ready = 1'b1;
    quiet();
    chk("read_access_count", accesses - base, 1);
    chk("read_q", rd_q, 16'hBEEF);
    chk("read_addr", mem_addr, 22'h201407);

    // Odd download byte.
    fixed_q_en = 0;
    base = accesses;
    raise_dl(16'h0003, 8'hA5);
    quiet();
    chk("dl_access_count", accesses - base, 1);
    chk("dl_bus", {mem_we, mem_addr, mem_din, mem_dqm}, {1'b1, 22'h000001, 16'hA5A5, 2'b01});

    // Starvation: rd and wr held continuously.
    fixed_lat = 0;
    grant_log.delete();
    log_en = 1; auto_rd = 1; auto_wr = 1;
    n = 0;
    while (grant_log.size() < 10 && n < 2000) begin
      step();
      n++;
    end
    auto_rd = 0; auto_wr = 0;
    quiet();
    log_en = 0;
    chk("starve_log_len", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("starve_seq_%0d", i), grant_log[i], (i == 8) ? K_WR : K_RD);

    // Random traffic with mem_ready glitches.
    rand_mode = 1;
    repeat (800) step();
    rand_mode = 0;
    mem_ready = 1'b1;
    quiet();

    // Reset in the middle of WAIT; the held write must be reissued once.
    fixed_lat = 6;
    raise_wr(1, 100, 200, 16'h1234);
    n = 0;
    while (!mem_req && n < 50) begin
      step();
      n++;
    end
    chk("wr_issue_seen", mem_req, 1);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {mem_req, mem_we, mem_addr, mem_din, mem_dqm, rd_q, rd_ack, wr_ack, dl_ack}, 0);
    step();
    step();
    base = accesses;
    base_wr = ack_cnt[K_WR];
    reset_n = 1'b1;
    quiet();
    chk("reissue_access_count", accesses - base, 1);
    chk("reissue_wr_acks", ack_cnt[K_WR] - base_wr, 1);

`ifdef ARB_STATS_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    fixed_lat = 0;
    repeat (3) begin
      raise_rd($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
      quiet();
    end
    repeat (2) begin
      raise_dl(16'($urandom), 8'($urandom));
      quiet();
    end
    chk("stat_rd", stat_rd, 3);
    chk("stat_dl", stat_dl, 2);
    chk("stat_wr", stat_wr, 0);
`endif

    repeat (3) step();
    chk("scoreboard_drained", exp_rd.size() + exp_wr.size() + exp_dl.size() + ackq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
